// File: rtl/bcd_accum_pkg.sv
// Shared definitions for the BCD accumulator: FSM state encoding,
// BCD digit constants and an operand validity helper.
package bcd_accum_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_t;

   localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
   localparam logic [3:0] BCD_CORR      = 4'd6;

   // True when both nibbles of a two-digit operand are legal BCD digits.
   function automatic logic is_bcd_pair(input logic [7:0] v);
      return (v[7:4] <= BCD_MAX_DIGIT) && (v[3:0] <= BCD_MAX_DIGIT);
   endfunction

endpackage

// File: rtl/bcd_accum_if.sv
// Operand handshake and result bus of the BCD accumulator.
// master = upstream/driver side, slave = accumulator side.
interface bcd_accum_if #(
   parameter int DIGITS = 4
);

   logic                clear;
   logic                in_valid;
   logic                in_ready;
   logic [7:0]          in_bcd;
   logic [4*DIGITS-1:0] sum;
   logic                out_valid;
   logic                ovf;
   logic                err;

   modport master (
      output clear, in_valid, in_bcd,
      input  in_ready, sum, out_valid, ovf, err
   );

   modport slave (
      input  clear, in_valid, in_bcd,
      output in_ready, sum, out_valid, ovf, err
   );

endinterface

// File: rtl/bcd_accum_digit_add.sv
// Single BCD digit adder with decimal correction: s = (a + b + cin) mod 10,
// cout set when the binary sum exceeds 9.
module bcd_digit_add
   import bcd_accum_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic [4:0] raw;
   logic [3:0] corrected;

   // Binary add, then add 6 (mod 16) to fold 10..19 back onto 0..9.
   always_comb begin
      raw       = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
      corrected = raw[3:0] + BCD_CORR;
      s         = raw[3:0];
      cout      = 1'b0;
      if (raw > {1'b0, BCD_MAX_DIGIT}) begin
         s    = corrected;
         cout = 1'b1;
      end
   end

endmodule

// File: rtl/bcd_accum.sv
// Digit-serial BCD running-total accumulator. Each accepted two-digit BCD
// operand is added one digit per clock into a copy of the total, which is
// committed with a one-cycle out_valid strobe.
// Optional build macro BCD_ACCUM_SAT_EN: saturate the total at all 9s on
// overflow instead of wrapping modulo 10^DIGITS.
module bcd_accum
   import bcd_accum_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   bcd_accum_if.slave  bus
);

   localparam int IDX_W = $clog2(DIGITS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   state_t state;
   state_t state_nxt;

   logic [DIGITS-1:0][3:0] sum_q;
   logic [DIGITS-1:0][3:0] work_q;
   logic [DIGITS-1:0][3:0] commit_val;
   logic [7:0]             operand_q;
   logic [IDX_W-1:0]       idx_q;
   logic                   carry_q;
   logic                   out_valid_q;
   logic                   ovf_q;
   logic                   err_q;

   logic                   in_ready;
   logic                   transfer;
   logic [3:0]             op_digit;
   logic [3:0]             add_s;
   logic                   add_cout;

   assign in_ready      = (state == IDLE) && !bus.clear;
   assign transfer      = bus.in_valid && in_ready;
   assign bus.in_ready  = in_ready;
   assign bus.sum       = sum_q;
   assign bus.out_valid = out_valid_q;
   assign bus.ovf       = ovf_q;
   assign bus.err       = err_q;

   // Operand digit for the current position; only the two low digits exist.
   always_comb begin
      op_digit = 4'd0;
      if (idx_q == '0) begin
         op_digit = operand_q[3:0];
      end else if (idx_q == IDX_W'(1)) begin
         op_digit = operand_q[7:4];
      end
   end

   bcd_digit_add u_digit_add (
      .a    (work_q[idx_q]),
      .b    (op_digit),
      .cin  (carry_q),
      .s    (add_s),
      .cout (add_cout)
   );

   // Value written to the visible total when an addition completes.
   always_comb begin
`ifdef BCD_ACCUM_SAT_EN
      commit_val = work_q;
      if (carry_q || ovf_q) begin
         commit_val = {DIGITS{BCD_MAX_DIGIT}};
      end
`else
      commit_val = work_q;
`endif
   end

   // State register; reset and clear both return the FSM to IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; clear overrides any in-progress sequence.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (transfer) state_nxt = is_bcd_pair(bus.in_bcd) ? ADD : ERR;
         ADD:  if (idx_q == LAST_IDX) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         ERR:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (bus.clear) begin
         state_nxt = IDLE;
      end
   end

   // Datapath: latch operand, walk the digits, commit total and sticky flags.
   always_ff @(posedge clk) begin
      if (!rst_n || bus.clear) begin
         sum_q       <= '0;
         work_q      <= '0;
         operand_q   <= '0;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (transfer) begin
                  operand_q <= bus.in_bcd;
                  work_q    <= sum_q;
                  idx_q     <= '0;
                  carry_q   <= 1'b0;
               end
            end
            ADD: begin
               work_q[idx_q] <= add_s;
               carry_q       <= add_cout;
               idx_q         <= idx_q + 1'b1;
            end
            DONE: begin
               sum_q       <= commit_val;
               out_valid_q <= 1'b1;
               if (carry_q) begin
                  ovf_q <= 1'b1;
               end
            end
            ERR: begin
               err_q <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_accum.sv
// Self-checking bench for bcd_accum: table-driven vectors, hand-written
// clear/reset sequences and randomized operands against a decimal model.
module tb_bcd_accum;

   localparam int DIGITS = 4;
   localparam int LIMIT  = 10000;

   logic clk;
   logic rst_n;

   bcd_accum_if #(.DIGITS(DIGITS)) bus ();

   bcd_accum #(.DIGITS(DIGITS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks_n = 0;
   int errors_n = 0;

   int m_total;
   bit m_ovf;
   bit m_err;

   typedef struct {
      logic [7:0]  in_bcd;
      bit          good;
      logic [15:0] exp_sum;
      bit          exp_ovf;
      bit          exp_err;
   } vec_t;

   vec_t vecs[7];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks_n++;
      if (act !== exp) begin
         errors_n++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int rem;
      r   = '0;
      rem = v;
      for (int d = 0; d < DIGITS; d++) begin
         r[4*d +: 4] = 4'(rem % 10);
         rem         = rem / 10;
      end
      return r;
   endfunction

   task automatic modelApply(input logic [7:0] val);
      if (val[7:4] > 9 || val[3:0] > 9) begin
         m_err = 1'b1;
      end else begin
         m_total = m_total + int'(val[7:4]) * 10 + int'(val[3:0]);
`ifdef BCD_ACCUM_SAT_EN
         if (m_ovf || m_total >= LIMIT) begin
            m_total = LIMIT - 1;
            m_ovf   = 1'b1;
         end
`else
         if (m_total >= LIMIT) begin
            m_total = m_total - LIMIT;
            m_ovf   = 1'b1;
         end
`endif
      end
   endtask

   // Called right after a transfer edge T: watches edges T..T+DIGITS+3.
   task automatic watchResult(output int seen_at, output int pulses);
      seen_at = -1;
      pulses  = 0;
      for (int k = 0; k <= DIGITS + 3; k++) begin
         @(negedge clk);
         if (k == 0) checkOutput("ready_low_after_transfer", 32'(bus.in_ready), 32'd0);
         if (bus.out_valid) begin
            pulses++;
            if (seen_at < 0) seen_at = k;
         end
      end
   endtask

   task automatic applyStimulus(input logic [7:0] val, input bit good);
      int cyc;
      int seen_at;
      int pulses;
      cyc = 0;
      @(negedge clk);
      while (!bus.in_ready && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      if (!bus.in_ready) begin
         checkOutput("ready_timeout", 32'(bus.in_ready), 32'd1);
         return;
      end
      bus.in_valid = 1'b1;
      bus.in_bcd   = val;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_bcd   = 8'($urandom);
      watchResult(seen_at, pulses);
      checkOutput("out_valid_latency", 32'(seen_at), good ? 32'(DIGITS + 1) : 32'hffffffff);
      checkOutput("out_valid_pulses", 32'(pulses), good ? 32'd1 : 32'd0);
   endtask

   task automatic pulseClear();
      @(negedge clk);
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      m_total = 0;
      m_ovf   = 1'b0;
      m_err   = 1'b0;
   endtask

   initial begin
      int seen_at;
      int pulses;
      logic [7:0] val;
      bit good;

      vecs[0] = '{8'h81, 1'b1, 16'h0081, 1'b0, 1'b0};
      vecs[1] = '{8'h81, 1'b1, 16'h0162, 1'b0, 1'b0};
      vecs[2] = '{8'h3A, 1'b0, 16'h0162, 1'b0, 1'b1};
      vecs[3] = '{8'h09, 1'b1, 16'h0171, 1'b0, 1'b1};
      vecs[4] = '{8'h99, 1'b1, 16'h0270, 1'b0, 1'b1};
      vecs[5] = '{8'hA0, 1'b0, 16'h0270, 1'b0, 1'b1};
      vecs[6] = '{8'h00, 1'b1, 16'h0270, 1'b0, 1'b1};

      rst_n        = 1'b0;
      bus.clear    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_bcd   = 8'h00;
      m_total      = 0;
      m_ovf        = 1'b0;
      m_err        = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_sum", 32'(bus.sum), 32'h0);
      checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("reset_ovf", 32'(bus.ovf), 32'd0);
      checkOutput("reset_err", 32'(bus.err), 32'd0);
      checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
      rst_n = 1'b1;

      $display("[TB] table vectors");
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].in_bcd, vecs[i].good);
         checkOutput($sformatf("vec%0d_sum", i), 32'(bus.sum), 32'(vecs[i].exp_sum));
         checkOutput($sformatf("vec%0d_ovf", i), 32'(bus.ovf), 32'(vecs[i].exp_ovf));
         checkOutput($sformatf("vec%0d_err", i), 32'(bus.err), 32'(vecs[i].exp_err));
      end

      $display("[TB] overflow run of 124 x 0x81");
      pulseClear();
      for (int i = 0; i < 124; i++) begin
         applyStimulus(8'h81, 1'b1);
         if (i == 122) begin
            checkOutput("pre_ovf_sum", 32'(bus.sum), 32'h9963);
            checkOutput("pre_ovf_flag", 32'(bus.ovf), 32'd0);
         end
      end
`ifdef BCD_ACCUM_SAT_EN
      checkOutput("ovf_sum", 32'(bus.sum), 32'h9999);
`else
      checkOutput("ovf_sum", 32'(bus.sum), 32'h0044);
`endif
      checkOutput("ovf_flag", 32'(bus.ovf), 32'd1);
      applyStimulus(8'h3A, 1'b0);
      checkOutput("err_after_bad", 32'(bus.err), 32'd1);

      $display("[TB] clear during ADD");
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_bcd   = 8'h45;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus.clear = 1'b1;
      @(negedge clk);
      checkOutput("clear_sum", 32'(bus.sum), 32'h0);
      checkOutput("clear_ovf", 32'(bus.ovf), 32'd0);
      checkOutput("clear_err", 32'(bus.err), 32'd0);
      checkOutput("clear_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("clear_ready_low", 32'(bus.in_ready), 32'd0);
      bus.clear = 1'b0;
      pulses = 0;
      for (int k = 0; k < DIGITS + 3; k++) begin
         @(negedge clk);
         if (bus.out_valid) pulses++;
      end
      checkOutput("clear_no_pulse", 32'(pulses), 32'd0);
      checkOutput("clear_ready_back", 32'(bus.in_ready), 32'd1);

      $display("[TB] clear with in_valid");
      bus.clear    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_bcd   = 8'h12;
      #1;
      checkOutput("clear_valid_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      bus.clear    = 1'b0;
      bus.in_valid = 1'b0;
      pulses = 0;
      for (int k = 0; k < DIGITS + 3; k++) begin
         @(negedge clk);
         if (bus.out_valid) pulses++;
      end
      checkOutput("clear_valid_no_pulse", 32'(pulses), 32'd0);
      checkOutput("clear_valid_sum", 32'(bus.sum), 32'h0);

      $display("[TB] reset during ADD");
      pulseClear();
      applyStimulus(8'h50, 1'b1);
      checkOutput("pre_reset_sum", 32'(bus.sum), 32'h0050);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_bcd   = 8'h11;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n        = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_bcd   = 8'h23;
      @(negedge clk);
      checkOutput("mid_reset_sum", 32'(bus.sum), 32'h0);
      checkOutput("mid_reset_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("mid_reset_ovf", 32'(bus.ovf), 32'd0);
      checkOutput("mid_reset_err", 32'(bus.err), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_bcd   = 8'hFF;
      watchResult(seen_at, pulses);
      checkOutput("post_reset_latency", 32'(seen_at), 32'(DIGITS + 1));
      checkOutput("post_reset_sum", 32'(bus.sum), 32'h0023);

      $display("[TB] randomized operands");
      pulseClear();
      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            val = 8'($urandom);
         end else begin
            val = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         end
         good = (val[7:4] <= 9) && (val[3:0] <= 9);
         modelApply(val);
         applyStimulus(val, good);
         checkOutput($sformatf("rnd%0d_sum", i), 32'(bus.sum), 32'(to_bcd(m_total)));
         checkOutput($sformatf("rnd%0d_ovf", i), 32'(bus.ovf), 32'(m_ovf));
         checkOutput($sformatf("rnd%0d_err", i), 32'(bus.err), 32'(m_err));
      end

      $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
      $finish;
   end

endmodule

// File: doc/bcd_accum.md
Name: bcd_accum

Overview:
- Downstream of the single-digit BCD multiplier stage. Consumes its 8-bit two-digit BCD product (00..99) and adds it into a multi-digit BCD running total.
- Addition is digit-serial: one BCD digit per clock, driven by a small FSM.
- Exposes a valid/ready input handshake and a one-cycle result strobe, so products can be summed for dot-product style exercises and shown on the display stage.

Parameters:
DIGITS, 4, number of BCD digits in the accumulator (legal range 2..8); total width 4*DIGITS.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous active-low reset.
clear  in  1  synchronous clear of total and flags; aborts any addition in progress.
in_valid  in  1  in_bcd holds an operand.
in_ready  out  1  block can accept an operand this cycle.
in_bcd  in  8  two BCD digits: [7:4] tens, [3:0] units.
sum  out  4*DIGITS  committed BCD total, digit 0 in [3:0].
out_valid  out  1  one-cycle pulse: sum was just updated.
ovf  out  1  sticky: total exceeded 10^DIGITS-1.
err  out  1  sticky: an operand contained a nibble greater than 9.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, sum=0, out_valid=0, ovf=0, err=0, work register=0, digit index=0. Reset wins over every other input.
- in_ready = (state==IDLE) && !clear. Transfer occurs when in_valid && in_ready at a clk edge.
- FSM states:
  - IDLE: on transfer, latch in_bcd and copy sum into the work register.
    - If either nibble of in_bcd is >9, go to ERR.
    - Otherwise go to ADD with idx=0 and carry=0.
  - ADD: each cycle, work[idx] = work[idx] + operand digit idx + carry, with BCD correction (result >9 means subtract 10 and set carry).
    - Operand digits with idx >= 2 are 0.
    - idx increments; after idx = DIGITS-1, go to DONE.
  - DONE: commit work to sum and assert out_valid for exactly this cycle.
    - If the final carry is 1, set ovf; sum wraps modulo 10^DIGITS.
    - Go to IDLE.
  - ERR: set err, leave sum unchanged, no out_valid, go to IDLE.
- Latency: a transfer at edge T produces sum/out_valid visible after edge T+DIGITS+1.
  - Throughput: one operand per DIGITS+2 cycles.
  - in_ready is low from the transfer edge until IDLE is re-entered.
- clear=1 (with rst_n=1), in any state: next state IDLE, sum=0, ovf=0, err=0, out_valid=0. The in-flight operand is discarded.
- clear and in_valid together in IDLE: clear wins and no transfer occurs, since in_ready is 0.
- in_bcd is sampled only at the transfer edge; later changes have no effect.
- in_valid while busy is ignored. The upstream stage holds in_valid until it sees in_ready.

Optional Feature:
- Macro: BCD_ACCUM_SAT_EN.
- Defined: on a final carry in DONE, sum saturates to all digits 9 and ovf is set. Once ovf=1, further additions leave sum at all 9s; out_valid still pulses.
- Undefined: wrap modulo 10^DIGITS as described in Behaviour.

Decomposition:
- Shared package/include holds:
  - state encoding constants: IDLE, ADD, DONE, ERR;
  - BCD_MAX_DIGIT = 9;
  - BCD correction constant = 6.
- One natural combinational sub-module: bcd_digit_add, with inputs a[3:0], b[3:0], cin and outputs s[3:0], cout. One instance is used in ADD, indexed by idx.

Test Plan:
- Reset, then one operand 0x81 -> out_valid pulses at T+5; sum=0x0081, ovf=0, err=0; in_ready high again on the following cycle.
- Operands 0x81 then 0x81 -> sum=0x0162 after the second out_valid.
- 124 operands of 0x81 (total 10044) -> wrap build: sum=0x0044, ovf=1. With BCD_ACCUM_SAT_EN: sum=0x9999, ovf=1.
- Operand 0x3A -> err=1, no out_valid, sum unchanged. A following 0x09 then adds normally and err stays 1.
- clear asserted at T+2 of an ADD sequence -> next cycle IDLE with sum=0, ovf=0, err=0 and no out_valid. clear+in_valid in the same IDLE cycle -> in_ready=0 and no transfer.
- rst_n=0 mid-ADD (sum previously 0x0050) -> all outputs at reset values next cycle. in_valid held across reset -> transfer occurs on the first cycle after rst_n=1.
